instr_fetch_unit: RTL and testbench

- Fetch/sequencer stage directly upstream of the 32x8 combinational program memory.
- Owns the program counter, drives the memory address, and assembles one- and two-byte instructions.
- Presents decoded-field instructions to the execute stage over a valid/ready handshake, then waits for execute's done/branch result before fetching again.
- Two-byte instructions: opcode 4'b0010 (load immediate) and 4'b1101 (jump-if-zero absolute). Opcode 4'b1111 is HALT.

---
 rtl/instr_fetch_unit.sv | 159 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetch/sequencer stage in front of a combinational program
//               memory. Owns the PC, assembles one- and two-byte
//               instructions, hands them to execute over valid/ready and
//               waits for execute's done/branch result before refetching.
//
// Ports       : clk            - system clock, rising edge
//               rst_n          - synchronous active-low reset
//               start          - leave IDLE and begin fetching at RESET_PC
//               pm_addr        - program memory address (always the PC)
//               pm_data        - combinational program memory read data
//               instr_valid    - decoded instruction fields valid
//               instr_ready    - execute accepts when valid & ready
//               instr_op       - opcode, byte[7:4]
//               instr_reg      - register/operand field, byte[3:0]
//               instr_imm      - second byte of two-byte ops, else 0
//               exec_done      - execute finished the accepted instruction
//               branch_taken   - with exec_done: redirect PC
//               branch_target  - new PC when branch_taken
//               halted         - HALT opcode fetched (sticky until reset)
//               busy           - high outside IDLE and HALTED
//
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] pm_addr,
    input  logic [DATA_W-1:0] pm_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [3:0]        instr_op,
    output logic [3:0]        instr_reg,
    output logic [DATA_W-1:0] instr_imm,
    input  logic              exec_done,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              halted,
    output logic              busy
);

    localparam logic [2:0] c_S_IDLE      = 3'd0;
    localparam logic [2:0] c_S_FETCH_OP  = 3'd1;
    localparam logic [2:0] c_S_FETCH_IMM = 3'd2;
    localparam logic [2:0] c_S_ISSUE     = 3'd3;
    localparam logic [2:0] c_S_WAIT_DONE = 3'd4;
    localparam logic [2:0] c_S_HALTED    = 3'd5;

    localparam logic [3:0] c_OP_LDI  = 4'b0010;
    localparam logic [3:0] c_OP_JZ   = 4'b1101;
    localparam logic [3:0] c_OP_HALT = 4'b1111;

    localparam logic [ADDR_W-1:0] c_RESET_PC = ADDR_W'(RESET_PC);

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_instr_valid;
    logic [3:0]        r_instr_op;
    logic [3:0]        r_instr_reg;
    logic [DATA_W-1:0] r_instr_imm;
    logic              r_halted;
    logic              r_busy;

    logic [3:0]        w_op;
    logic [3:0]        w_reg;
    logic [ADDR_W-1:0] w_pc_inc;

    assign w_op     = pm_data[DATA_W-1 -: 4];
    assign w_reg    = pm_data[3:0];
    // Increment wraps naturally at 2^ADDR_W; the carry is discarded.
    assign w_pc_inc = r_pc + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= c_S_IDLE;
            r_pc          <= c_RESET_PC;
            r_instr_valid <= 1'b0;
            r_instr_op    <= '0;
            r_instr_reg   <= '0;
            r_instr_imm   <= '0;
            r_halted      <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_pc    <= c_RESET_PC;
                        r_state <= c_S_FETCH_OP;
                        r_busy  <= 1'b1;
                    end
                end
                c_S_FETCH_OP: begin
                    r_instr_op  <= w_op;
                    r_instr_reg <= w_reg;
                    r_instr_imm <= '0;
                    r_pc        <= w_pc_inc;
                    if (w_op == c_OP_HALT) begin
                        r_state  <= c_S_HALTED;
                        r_halted <= 1'b1;
                        r_busy   <= 1'b0;
                    end else if (w_op == c_OP_LDI || w_op == c_OP_JZ) begin
                        r_state <= c_S_FETCH_IMM;
                    end else begin
                        r_state       <= c_S_ISSUE;
                        r_instr_valid <= 1'b1;
                    end
                end
                c_S_FETCH_IMM: begin
                    r_instr_imm   <= pm_data;
                    r_pc          <= w_pc_inc;
                    r_state       <= c_S_ISSUE;
                    r_instr_valid <= 1'b1;
                end
                c_S_ISSUE: begin
                    // Valid is a pure register; fields hold until accepted.
                    if (instr_ready) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= c_S_WAIT_DONE;
                    end
                end
                c_S_WAIT_DONE: begin
                    // PC already points past the instruction; only a taken
                    // branch overrides it.
                    if (exec_done) begin
                        if (branch_taken) begin
                            r_pc <= branch_target;
                        end
                        r_state <= c_S_FETCH_OP;
                    end
                end
                c_S_HALTED: begin
                    r_state <= c_S_HALTED;
                end
                default: begin
                    r_state       <= c_S_IDLE;
                    r_instr_valid <= 1'b0;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

    assign pm_addr     = r_pc;
    assign instr_valid = r_instr_valid;
    assign instr_op    = r_instr_op;
    assign instr_reg   = r_instr_reg;
    assign instr_imm   = r_instr_imm;
    assign halted      = r_halted;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Self-checking bench for instr_fetch_unit. A behavioural
//               32x8 program memory feeds the DUT; expected instructions are
//               queued by each scenario and compared when execute accepts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] rg;
        logic [7:0] imm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [4:0] pm_addr;
    logic [7:0] pm_data;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] instr_op;
    logic [3:0] instr_reg;
    logic [7:0] instr_imm;
    logic       exec_done;
    logic       branch_taken;
    logic [4:0] branch_target;
    logic       halted;
    logic       busy;

    logic [7:0] pm [32];
    exp_t       sb [$];
    exp_t       r_exp;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    assign pm_data = pm[pm_addr];

    instr_fetch_unit #(
        .ADDR_W   (5),
        .DATA_W   (8),
        .RESET_PC (0)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .pm_addr       (pm_addr),
        .pm_data       (pm_data),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_op      (instr_op),
        .instr_reg     (instr_reg),
        .instr_imm     (instr_imm),
        .exec_done     (exec_done),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halted        (halted),
        .busy          (busy)
    );

    // Scoreboard: every accepted instruction must match the queued one.
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_underflow: issued op=%h reg=%h imm=%h, expected none",
                         instr_op, instr_reg, instr_imm);
            end else begin
                r_exp = sb.pop_front();
                if ({instr_op, instr_reg, instr_imm} !== r_exp) begin
                    n_err++;
                    $display("FAIL sb_instr: got op=%h reg=%h imm=%h, expected op=%h reg=%h imm=%h",
                             instr_op, instr_reg, instr_imm, r_exp.op, r_exp.rg, r_exp.imm);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, start, run PM[0]=0x10 through a handshake, then branch to target.
    task automatic springboard(input logic [4:0] target);
        pm[0]        = 8'h10;
        rst_n        = 1'b0;
        start        = 1'b0;
        exec_done    = 1'b0;
        branch_taken = 1'b0;
        instr_ready  = 1'b1;
        tick();
        rst_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        sb.push_back({4'h1, 4'h0, 8'h00});
        tick();
        tick();
        exec_done     = 1'b1;
        branch_taken  = 1'b1;
        branch_target = target;
        tick();
        exec_done    = 1'b0;
        branch_taken = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; exec_done = 1'b1; branch_taken = 1'b1;
        branch_target = 5'd7; instr_ready = 1'b1;
        tick();
        n_cmp++;
        if ({instr_valid, halted, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags: valid/halted/busy=%b, expected 000", {instr_valid, halted, busy});
        end
        n_cmp++;
        if ({pm_addr, instr_op, instr_reg, instr_imm} !== 21'd0) begin
            n_err++;
            $display("FAIL reset_fields: addr=%0d op=%h reg=%h imm=%h, expected all 0",
                     pm_addr, instr_op, instr_reg, instr_imm);
        end
        rst_n = 1'b1; start = 1'b0; exec_done = 1'b0; branch_taken = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (busy !== 1'b0 || pm_addr !== 5'd0) begin
            n_err++;
            $display("FAIL idle_hold: busy=%b addr=%0d, expected busy=0 addr=0", busy, pm_addr);
        end
    endtask

    task automatic test_start_single();
        pm[0] = 8'h10;
        instr_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (pm_addr !== 5'd0 || busy !== 1'b1 || instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL start_fetch: addr=%0d busy=%b valid=%b, expected 0 1 0", pm_addr, busy, instr_valid);
        end
        sb.push_back({4'h1, 4'h0, 8'h00});
        tick();
        n_cmp++;
        if (instr_valid !== 1'b1 || pm_addr !== 5'd1) begin
            n_err++;
            $display("FAIL start_latency: valid=%b addr=%0d, expected valid=1 addr=1", instr_valid, pm_addr);
        end
        tick();
        n_cmp++;
        if (instr_valid !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL accept_drop: valid=%b busy=%b, expected 0 1", instr_valid, busy);
        end
    endtask

    task automatic test_two_byte();
        pm[2] = 8'h20; pm[3] = 8'h01; pm[4] = 8'h30;
        springboard(5'd2);
        n_cmp++;
        if (pm_addr !== 5'd2) begin
            n_err++;
            $display("FAIL branch_to_2: addr=%0d, expected 2", pm_addr);
        end
        sb.push_back({4'h2, 4'h0, 8'h01});
        tick();
        n_cmp++;
        if (pm_addr !== 5'd3 || instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL fetch_imm: addr=%0d valid=%b, expected addr=3 valid=0", pm_addr, instr_valid);
        end
        tick();
        n_cmp++;
        if (pm_addr !== 5'd4 || instr_valid !== 1'b1) begin
            n_err++;
            $display("FAIL two_byte_issue: addr=%0d valid=%b, expected addr=4 valid=1", pm_addr, instr_valid);
        end
        tick();
        exec_done = 1'b1; branch_taken = 1'b0;
        tick();
        exec_done = 1'b0;
        n_cmp++;
        if (pm_addr !== 5'd4 || instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL not_taken: addr=%0d valid=%b, expected addr=4 valid=0", pm_addr, instr_valid);
        end
        sb.push_back({4'h3, 4'h0, 8'h00});
        tick();
        n_cmp++;
        if (instr_valid !== 1'b1) begin
            n_err++;
            $display("FAIL done_latency: valid=%b, expected 1", instr_valid);
        end
        tick();
    endtask

    task automatic test_branch();
        pm[23] = 8'hD0; pm[24] = 8'h15; pm[21] = 8'h60;
        springboard(5'd23);
        sb.push_back({4'hD, 4'h0, 8'h15});
        tick(); tick(); tick();
        exec_done = 1'b1; branch_taken = 1'b1; branch_target = 5'd21;
        tick();
        exec_done = 1'b0; branch_taken = 1'b0;
        n_cmp++;
        if (pm_addr !== 5'd21 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL branch_taken: addr=%0d busy=%b, expected addr=21 busy=1", pm_addr, busy);
        end
        sb.push_back({4'h6, 4'h0, 8'h00});
        tick(); tick();
        exec_done = 1'b1; branch_taken = 1'b1; branch_target = 5'd23;
        tick();
        exec_done = 1'b0; branch_taken = 1'b0;
        sb.push_back({4'hD, 4'h0, 8'h15});
        tick(); tick(); tick();
        exec_done = 1'b1; branch_taken = 1'b0;
        tick();
        exec_done = 1'b0;
        n_cmp++;
        if (pm_addr !== 5'd25) begin
            n_err++;
            $display("FAIL jz_not_taken: addr=%0d, expected 25", pm_addr);
        end
    endtask

    task automatic test_backpressure();
        pm[5] = 8'h51; pm[6] = 8'h70;
        springboard(5'd5);
        instr_ready = 1'b0;
        sb.push_back({4'h5, 4'h1, 8'h00});
        tick();
        for (int i = 0; i < 5; i++) begin
            exec_done = 1'b1; branch_taken = 1'b1; branch_target = 5'd9;
            tick();
            n_cmp++;
            if (instr_valid !== 1'b1 || instr_op !== 4'h5 || instr_reg !== 4'h1 || pm_addr !== 5'd6) begin
                n_err++;
                $display("FAIL hold_%0d: valid=%b op=%h reg=%h addr=%0d, expected 1 5 1 6",
                         i, instr_valid, instr_op, instr_reg, pm_addr);
            end
        end
        exec_done = 1'b0; branch_taken = 1'b0;
        instr_ready = 1'b1;
        tick();
        branch_taken = 1'b1; branch_target = 5'd9;
        tick();
        n_cmp++;
        if (pm_addr !== 5'd6 || instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL taken_no_done: addr=%0d valid=%b, expected addr=6 valid=0", pm_addr, instr_valid);
        end
        exec_done = 1'b1; branch_taken = 1'b0;
        tick();
        exec_done = 1'b0;
        sb.push_back({4'h7, 4'h0, 8'h00});
        tick(); tick();
    endtask

    task automatic test_wrap();
        pm[31] = 8'h20;
        springboard(5'd31);
        n_cmp++;
        if (pm_addr !== 5'd31) begin
            n_err++;
            $display("FAIL branch_to_31: addr=%0d, expected 31", pm_addr);
        end
        sb.push_back({4'h2, 4'h0, 8'h10});
        tick();
        n_cmp++;
        if (pm_addr !== 5'd0) begin
            n_err++;
            $display("FAIL wrap_imm_addr: addr=%0d, expected 0", pm_addr);
        end
        tick();
        n_cmp++;
        if (pm_addr !== 5'd1 || instr_valid !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_pc: addr=%0d valid=%b, expected addr=1 valid=1", pm_addr, instr_valid);
        end
        tick();
    endtask

    task automatic test_reset_mid_fetch();
        springboard(5'd2);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_cmp++;
        if (pm_addr !== 5'd0 || instr_valid !== 1'b0 || busy !== 1'b0 || instr_op !== 4'h0) begin
            n_err++;
            $display("FAIL mid_reset: addr=%0d valid=%b busy=%b op=%h, expected 0 0 0 0",
                     pm_addr, instr_valid, busy, instr_op);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (pm_addr !== 5'd0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL restart: addr=%0d busy=%b, expected addr=0 busy=1", pm_addr, busy);
        end
        sb.push_back({4'h1, 4'h0, 8'h00});
        tick(); tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (pm_addr !== 5'd1 || instr_valid !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL start_ignored: addr=%0d valid=%b busy=%b, expected 1 0 1", pm_addr, instr_valid, busy);
        end
    endtask

    task automatic test_halt();
        pm[8] = 8'hF0;
        springboard(5'd8);
        tick();
        n_cmp++;
        if (halted !== 1'b1 || busy !== 1'b0 || instr_valid !== 1'b0 || pm_addr !== 5'd9) begin
            n_err++;
            $display("FAIL halt: halted=%b busy=%b valid=%b addr=%0d, expected 1 0 0 9",
                     halted, busy, instr_valid, pm_addr);
        end
        start = 1'b1; exec_done = 1'b1; branch_taken = 1'b1; branch_target = 5'd3;
        tick(); tick(); tick();
        start = 1'b0; exec_done = 1'b0; branch_taken = 1'b0;
        n_cmp++;
        if (halted !== 1'b1 || busy !== 1'b0 || instr_valid !== 1'b0 || pm_addr !== 5'd9) begin
            n_err++;
            $display("FAIL halt_sticky: halted=%b busy=%b valid=%b addr=%0d, expected 1 0 0 9",
                     halted, busy, instr_valid, pm_addr);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) pm[i] = 8'h00;
        rst_n = 1'b0; start = 1'b0; instr_ready = 1'b0;
        exec_done = 1'b0; branch_taken = 1'b0; branch_target = 5'd0;
        test_reset();
        test_start_single();
        test_two_byte();
        test_branch();
        test_backpressure();
        test_wrap();
        test_reset_mid_fetch();
        test_halt();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: %0d instructions never issued, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
